// File: rtl/ring_shift_sequencer.sv
// ---------------------------------------------------------------------------
// ring_shift_sequencer
//
// Job controller for a W-bit right-rotating ring shift register. A job is
// accepted with a start handshake. The controller then clears the ring and
// shifts the latched word in serially, LSB first. Next it lets the ring rotate
// for the requested number of steps. Finally it captures the ring contents
// and compares them with the rotation it expects.
//
// The ring datapath rotates right on every clock where neither its load nor
// its reset is asserted. This controller never asks the ring to hold a value.
// Instead it schedules the job around that free-running rotation.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-low reset (0 = reset)
//   start    job request, only looked at while idle
//   data_in  word to load, latched when start is accepted
//   steps    rotations after load, latched when start is accepted
//   busy     high while a job is in flight (CLEAR/LOAD/ROTATE/CAPTURE)
//   done     one-cycle pulse when result/err are updated
//   result   ring contents captured at the end of the last job
//   err      result differed from the expected rotation of the last job
//   sh_rst   datapath reset (active-high, asynchronous in the datapath)
//   sh_ld    datapath serial-load enable
//   sh_in    datapath serial-load bit
//   ring_q   datapath parallel output
// ---------------------------------------------------------------------------
module ring_shift_sequencer #(
  parameter int W     = 6,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     data_in,
  input  logic [CNT_W-1:0] steps,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result,
  output logic             err,
  output logic             sh_rst,
  output logic             sh_ld,
  output logic             sh_in,
  input  logic [W-1:0]     ring_q
);

  localparam int          IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [31:0] W_U   = 32'(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_ROTATE,
    S_CAPTURE
  } state_t;

  state_t state, state_nx;

  // Job context latched at start
  logic [W-1:0]     wd, wd_nx;
  logic [CNT_W-1:0] n, n_nx;

  // Load bit index, load shift copy, and rotation counter
  logic [IDX_W-1:0] idx, idx_nx;
  logic [W-1:0]     ld_sr, ld_sr_nx;
  logic [CNT_W-1:0] rc, rc_nx;

  // Next values for registered outputs
  logic             sh_rst_nx, sh_ld_nx, sh_in_nx, done_nx;
  logic [W-1:0]     result_nx;
  logic             err_nx;

  // Expected ring contents at capture
  logic [31:0]      rot_amt;
  logic [W-1:0]     exp_word;

  // The expected word is the latched word rotated right by (n mod W).
  // W need not be a power of two, so a true modulo is used here and not a
  // truncation of n. Shifting the doubled word right and keeping the low W
  // bits gives a right rotation by any amount in 0..W-1.
  always_comb begin
    rot_amt  = 32'(n) % W_U;
    exp_word = W'({wd, wd} >> rot_amt);
  end

  // busy is a plain decode of the state register, so it has no path from
  // any input.
  assign busy = (state != S_IDLE);

  // Next-state and next-output logic.
  // The sh_* pins come straight from flops, so the datapath's asynchronous
  // reset never sees a glitch. Each sh_* pin therefore carries the value
  // that belongs to the state being entered on this edge.
  // During LOAD, ld_sr supplies the next serial bit. The first bit is
  // presented on the CLEAR->LOAD edge, so LOAD lasts exactly W cycles.
  // The rotation counter is compared before it is incremented, so
  // steps = 2^CNT_W-1 never wraps rc.
  always_comb begin
    state_nx  = state;
    wd_nx     = wd;
    n_nx      = n;
    idx_nx    = idx;
    ld_sr_nx  = ld_sr;
    rc_nx     = rc;
    sh_rst_nx = 1'b0;
    sh_ld_nx  = 1'b0;
    sh_in_nx  = 1'b0;
    done_nx   = 1'b0;
    result_nx = result;
    err_nx    = err;

    case (state)
      S_IDLE: begin
        if (start) begin
          wd_nx     = data_in;
          n_nx      = steps;
          sh_rst_nx = 1'b1;
          state_nx  = S_CLEAR;
        end
      end

      S_CLEAR: begin
        idx_nx   = '0;
        sh_ld_nx = 1'b1;
        sh_in_nx = wd[0];
        ld_sr_nx = wd >> 1;
        state_nx = S_LOAD;
      end

      S_LOAD: begin
        if (idx == IDX_W'(W - 1)) begin
          if (n == '0) begin
            state_nx = S_CAPTURE;
          end else begin
            rc_nx    = '0;
            state_nx = S_ROTATE;
          end
        end else begin
          idx_nx   = idx + IDX_W'(1);
          sh_ld_nx = 1'b1;
          sh_in_nx = ld_sr[0];
          ld_sr_nx = ld_sr >> 1;
        end
      end

      S_ROTATE: begin
        if (rc == n - CNT_W'(1)) begin
          state_nx = S_CAPTURE;
        end else begin
          rc_nx = rc + CNT_W'(1);
        end
      end

      S_CAPTURE: begin
        result_nx = ring_q;
        err_nx    = (ring_q != exp_word);
        done_nx   = 1'b1;
        state_nx  = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  // Reset clears all of them, including a job in progress. An aborted job
  // never produces a done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      wd     <= '0;
      n      <= '0;
      idx    <= '0;
      ld_sr  <= '0;
      rc     <= '0;
      sh_rst <= 1'b0;
      sh_ld  <= 1'b0;
      sh_in  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      wd     <= wd_nx;
      n      <= n_nx;
      idx    <= idx_nx;
      ld_sr  <= ld_sr_nx;
      rc     <= rc_nx;
      sh_rst <= sh_rst_nx;
      sh_ld  <= sh_ld_nx;
      sh_in  <= sh_in_nx;
      done   <= done_nx;
      result <= result_nx;
      err    <= err_nx;
    end
  end

endmodule

// File: tb/tb_ring_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ring_shift_sequencer
//
// Bench for ring_shift_sequencer. It contains a behavioural model of the
// 6-bit right-rotating ring datapath. Jobs are issued from directed vectors.
// The expected result of each job is hand-computed. It is pushed into a
// scoreboard queue together with the cycle in which done is due. A separate
// monitor pops and compares each entry when done pulses.
// ---------------------------------------------------------------------------
module tb_ring_shift_sequencer;

  localparam int W     = 6;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     data_in;
  logic [CNT_W-1:0] steps;
  logic             busy;
  logic             done;
  logic [W-1:0]     result;
  logic             err;
  logic             sh_rst;
  logic             sh_ld;
  logic             sh_in;
  logic [W-1:0]     ring_q;

  logic [W-1:0]     ring;
  logic             corrupt_en = 1'b0;
  int               cyc = 0;
  int               vectors = 0;
  int               miscompares = 0;

  typedef struct {
    logic [W-1:0] result;
    logic         err;
    int           done_cyc;
    string        name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Count the rising edges so that done latency can be checked.
  always @(posedge clk) cyc <= cyc + 1;

  // Ring datapath model. Reset is asynchronous and active-high. With ld set,
  // in_bit enters at the MSB. Otherwise the ring rotates right, so bit0
  // moves to the MSB.
  always @(posedge clk or posedge sh_rst) begin
    if (sh_rst)     ring <= '0;
    else if (sh_ld) ring <= {sh_in, ring[W-1:1]};
    else            ring <= {ring[0], ring[W-1:1]};
  end

  // Fault injection: invert bit0 only while the controller is neither
  // clearing nor loading the ring. With steps = 0 that is exactly the
  // capture cycle.
  assign ring_q = (corrupt_en && busy && !sh_ld && !sh_rst) ? (ring ^ 6'b000001) : ring;

  ring_shift_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .steps   (steps),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err),
    .sh_rst  (sh_rst),
    .sh_ld   (sh_ld),
    .sh_in   (sh_in),
    .ring_q  (ring_q)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending job.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected no done", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_result"},  32'(result), 32'(e.result));
        checkOutput({e.name, "_err"},     32'(err),    32'(e.err));
        checkOutput({e.name, "_latency"}, 32'(cyc),    32'(e.done_cyc));
      end
    end
  end

  // Wait, with a cycle bound, until no job is pending or running.
  task automatic waitIdle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_idle: got busy=%0b pending=%0d, expected idle", busy, sb.size());
    end
  endtask

  // Present a job at the current negedge. It is accepted on the next rising
  // edge, and done is due n+8 edges after that edge.
  task automatic issueJob(input logic [W-1:0] d, input logic [CNT_W-1:0] s,
                          input logic [W-1:0] exp_res, input logic exp_err,
                          input bit expect_done, input bit corrupt, input string name);
    exp_t e;
    data_in    = d;
    steps      = s;
    start      = 1'b1;
    corrupt_en = corrupt;
    if (expect_done) begin
      e.result   = exp_res;
      e.err      = exp_err;
      e.done_cyc = cyc + 1 + int'(s) + 8;
      e.name     = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [W-1:0] d, input logic [CNT_W-1:0] s,
                               input logic [W-1:0] exp_res, input logic exp_err,
                               input bit expect_done, input bit corrupt, input string name);
    waitIdle(200);
    issueJob(d, s, exp_res, exp_err, expect_done, corrupt, name);
  endtask

  initial begin
    int          rst_cnt;
    int          ld_cnt;
    logic [W-1:0] ld_bits;
    bit          seen;

    // Reset asserted for two edges while start is requested
    rst     = 1'b0;
    start   = 1'b1;
    data_in = 6'b111111;
    steps   = 6'd63;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy",   32'(busy),   32'd0);
    checkOutput("reset_done",   32'(done),   32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_err",    32'(err),    32'd0);
    checkOutput("reset_sh_rst", 32'(sh_rst), 32'd0);
    checkOutput("reset_sh_ld",  32'(sh_ld),  32'd0);
    checkOutput("reset_sh_in",  32'(sh_in),  32'd0);
    rst   = 1'b1;
    start = 1'b0;

    // Load only: watch the serial pins through the job
    @(negedge clk);
    issueJob(6'b000001, 6'd0, 6'b000001, 1'b0, 1'b1, 1'b0, "load_only");
    rst_cnt = 0;
    ld_cnt  = 0;
    ld_bits = '0;
    repeat (10) begin
      @(negedge clk);
      if (sh_rst) rst_cnt++;
      if (sh_ld) begin
        ld_cnt++;
        ld_bits = {sh_in, ld_bits[W-1:1]};
      end
    end
    checkOutput("sh_rst_cycles", 32'(rst_cnt), 32'd1);
    checkOutput("sh_ld_cycles",  32'(ld_cnt),  32'd6);
    checkOutput("sh_in_seq",     32'(ld_bits), 32'b000001);

    // Rotation amounts, including a full turn and the largest step count
    applyStimulus(6'b000001, 6'd1,  6'b100000, 1'b0, 1'b1, 1'b0, "rot1");
    applyStimulus(6'b000001, 6'd2,  6'b010000, 1'b0, 1'b1, 1'b0, "rot2");
    applyStimulus(6'b101100, 6'd6,  6'b101100, 1'b0, 1'b1, 1'b0, "rot6");
    applyStimulus(6'b000111, 6'd63, 6'b111000, 1'b0, 1'b1, 1'b0, "rot63");

    // start pulses during LOAD and during ROTATE must be ignored
    applyStimulus(6'b001011, 6'd4, 6'b101100, 1'b0, 1'b1, 1'b0, "ignore_busy");
    repeat (2) @(negedge clk);
    checkOutput("busy_in_load", 32'(sh_ld), 32'd1);
    data_in = 6'b111111;
    steps   = 6'd0;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("busy_in_rotate", 32'(busy && !sh_ld && !sh_rst), 32'd1);
    data_in = 6'b111111;
    steps   = 6'd0;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitIdle(200);

    // Back-to-back: second start held high in the done cycle of the first
    applyStimulus(6'b000011, 6'd1, 6'b100001, 1'b0, 1'b1, 1'b0, "b2b_first");
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL b2b_wait_done: got no done, expected done within 50 cycles");
    end
    issueJob(6'b110000, 6'd2, 6'b001100, 1'b0, 1'b1, 1'b0, "b2b_second");
    waitIdle(200);

    // Reset in the middle of ROTATE aborts the job with no done pulse
    applyStimulus(6'b101010, 6'd20, 6'b000000, 1'b0, 1'b0, 1'b0, "abort");
    repeat (12) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy",   32'(busy),   32'd0);
    checkOutput("abort_done",   32'(done),   32'd0);
    checkOutput("abort_sh_ld",  32'(sh_ld),  32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    applyStimulus(6'b110010, 6'd3, 6'b010110, 1'b0, 1'b1, 1'b0, "after_abort");

    // Corrupted capture flags err, which is held until the next clean job
    applyStimulus(6'b000001, 6'd0, 6'b000000, 1'b1, 1'b1, 1'b1, "corrupt");
    waitIdle(200);
    @(negedge clk);
    checkOutput("err_held", 32'(err), 32'd1);
    applyStimulus(6'b000001, 6'd1, 6'b100000, 1'b0, 1'b1, 1'b0, "clean_after_err");
    waitIdle(200);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout at cycle %0d, expected bench to finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
